// File: rtl/txwb_pkg.sv
// Shared types and helpers for the count-driven TX read controller.
package txwb_pkg;

  localparam int unsigned BeatBytes = 8;
  localparam int unsigned TagW      = 9;  // {last, keep[7:0]}

  typedef enum logic [1:0] {
    StIdle,
    StCntWait,
    StXfer
  } state_e;

  // Byte-enable mask for the final beat; a zero remainder means a full beat.
  function automatic logic [7:0] last_keep(input logic [2:0] rem);
    logic [8:0] mask;
    mask = (9'd1 << rem) - 9'd1;
    last_keep = (rem == 3'd0) ? 8'hFF : mask[7:0];
  endfunction

endpackage

// File: rtl/txwb_skid2.sv
// Two-entry skid FIFO holding data FIFO return words plus their {last, keep} tag.
module txwb_skid2 #(
  parameter int unsigned Width = 64,
  parameter int unsigned TagW  = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [TagW-1:0]  wtag_i,
  input  logic             rd_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [TagW-1:0]  tag_o,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] data0_q, data1_q;
  logic [TagW-1:0]  tag0_q, tag1_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;
  logic             pop;

  assign pop     = rd_i && (occ_q != 2'd0);
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

  // Idle bus reads as zero so the stream outputs are clean outside a beat.
  assign data_o = !valid_o ? '0 : (rd_ptr_q ? data1_q : data0_q);
  assign tag_o  = !valid_o ? '0 : (rd_ptr_q ? tag1_q : tag0_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data0_q  <= '0;
      data1_q  <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (wr_i) begin
        if (wr_ptr_q) begin
          data1_q <= wdata_i;
          tag1_q  <= wtag_i;
        end else begin
          data0_q <= wdata_i;
          tag0_q  <= wtag_i;
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, wr_i} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/txwbcnt_rdctrl.sv
// Pops a byte count, then streams that packet's words from the data FIFO onto AXI-Stream.
module txwbcnt_rdctrl
  import txwb_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             cnt_rden,
  input  logic [63:0]      cnt_dout,
  input  logic             cnt_rdempty,
  output logic             dat_rden,
  input  logic [WIDTH-1:0] dat_dout,
  input  logic             dat_rdempty,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic [7:0]       m_tkeep,
  output logic             m_tlast,
  output logic             busy,
  output logic             err_zero_len,
  output logic [15:0]      pkt_cnt
);

  localparam int unsigned WordsW = LEN_W - 2;

  state_e            state_q;
  logic [WordsW-1:0] words_left_q;
  logic [7:0]        last_keep_q;
  logic              rd_pend_q;
  logic [TagW-1:0]   pend_tag_q;
  logic              err_q;
  logic [15:0]       pkt_cnt_q;

  logic [LEN_W-1:0]  bytes;
  logic [LEN_W:0]    words_sum;
  logic [WordsW-1:0] words_calc;
  logic [1:0]        skid_occ;
  logic [2:0]        fill;
  logic              hs;
  logic              rd_last;
  logic [TagW-1:0]   skid_tag;
  logic              unused_cnt_hi;

  assign bytes         = cnt_dout[LEN_W-1:0];
  assign unused_cnt_hi = ^cnt_dout[63:LEN_W];
  // One extra bit keeps 65535 bytes from wrapping: 65542 >> 3 = 8192.
  assign words_sum  = {1'b0, bytes} + (LEN_W + 1)'(BeatBytes - 1);
  assign words_calc = words_sum[LEN_W:3];

  assign hs      = m_tvalid && m_tready;
  assign rd_last = (words_left_q == WordsW'(1));
  // Slots committed after this edge: stored + in flight - leaving.
  assign fill    = {1'b0, skid_occ} + {2'b0, rd_pend_q} - {2'b0, hs};

  assign cnt_rden = (state_q == StIdle) && !cnt_rdempty && !reset;
  assign dat_rden = (state_q == StXfer) && (words_left_q != '0) && !dat_rdempty &&
                    (fill < 3'd2);

  assign busy         = (state_q != StIdle);
  assign err_zero_len = err_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign m_tlast      = skid_tag[8];
  assign m_tkeep      = skid_tag[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      words_left_q <= '0;
      last_keep_q  <= 8'h00;
      rd_pend_q    <= 1'b0;
      pend_tag_q   <= '0;
      err_q        <= 1'b0;
      pkt_cnt_q    <= 16'd0;
    end else begin
      rd_pend_q <= dat_rden;
      err_q     <= 1'b0;
      if (dat_rden) begin
        pend_tag_q <= {rd_last, rd_last ? last_keep_q : 8'hFF};
      end
      unique case (state_q)
        StIdle: begin
          if (cnt_rden) state_q <= StCntWait;
        end
        StCntWait: begin
          if (bytes == '0) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            words_left_q <= words_calc;
            last_keep_q  <= last_keep(bytes[2:0]);
            state_q      <= StXfer;
          end
        end
        StXfer: begin
          if (dat_rden) words_left_q <= words_left_q - WordsW'(1);
          if (hs && m_tlast) begin
            state_q   <= StIdle;
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  txwb_skid2 #(
    .Width (WIDTH),
    .TagW  (TagW)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_i    (rd_pend_q),
    .wdata_i (dat_dout),
    .wtag_i  (pend_tag_q),
    .rd_i    (m_tready),
    .valid_o (m_tvalid),
    .data_o  (m_tdata),
    .tag_o   (skid_tag),
    .occ_o   (skid_occ)
  );

endmodule

// File: tb/tb_txwbcnt_rdctrl.sv
// Self-checking bench: FIFO models with one-cycle read latency and a beat scoreboard.
module tb_txwbcnt_rdctrl;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cnt_rden;
  logic [63:0]      cnt_dout = '0;
  logic             cnt_rdempty;
  logic             dat_rden;
  logic [WIDTH-1:0] dat_dout = '0;
  logic             dat_rdempty;
  logic             m_tvalid;
  logic             m_tready;
  logic [WIDTH-1:0] m_tdata;
  logic [7:0]       m_tkeep;
  logic             m_tlast;
  logic             busy;
  logic             err_zero_len;
  logic [15:0]      pkt_cnt;

  always #5 clk = ~clk;

  txwbcnt_rdctrl #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_rden     (cnt_rden),
    .cnt_dout     (cnt_dout),
    .cnt_rdempty  (cnt_rdempty),
    .dat_rden     (dat_rden),
    .dat_dout     (dat_dout),
    .dat_rdempty  (dat_rdempty),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .busy         (busy),
    .err_zero_len (err_zero_len),
    .pkt_cnt      (pkt_cnt)
  );

  // FIFO models
  logic [63:0]      cnt_mem [64];
  logic [WIDTH-1:0] dat_mem [1024];
  int               cnt_wr = 0, cnt_rd = 0, dat_wr = 0, dat_rd = 0;
  logic             dat_flush = 1'b0;

  assign cnt_rdempty = (cnt_rd == cnt_wr);
  assign dat_rdempty = (dat_rd == dat_wr);

  always @(posedge clk) begin
    if (cnt_rden) begin
      cnt_dout <= cnt_mem[cnt_rd[5:0]];
      cnt_rd   <= cnt_rd + 1;
    end
    if (dat_flush) begin
      dat_rd <= dat_wr;
    end else if (dat_rden) begin
      dat_dout <= dat_mem[dat_rd[9:0]];
      dat_rd   <= dat_rd + 1;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [7:0]       keep;
    logic             last;
  } beat_t;

  typedef struct {
    int unsigned bytes;
    int unsigned ready_mode;  // 0 always ready, 1 toggle, 2 random
    int unsigned exp_beats;
    logic [7:0]  exp_last_keep;
  } vec_t;

  beat_t exp_q[$];
  beat_t mon_e;
  vec_t  vecs[6];

  int checks = 0, errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int beats, first_hs, last_hs, cnt_rden_cyc, first_valid_cyc, err_pulses, dat_rd_cnt;
  int max_occ;
  logic [7:0] last_keep_seen;
  logic stall_prev = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic [7:0] prev_keep;
  logic prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_keep(input int unsigned bytes, input bit last);
    int unsigned r;
    r = bytes % 8;
    exp_keep = 8'hFF;
    if (last && r != 0) begin
      exp_keep = 8'h00;
      for (int b = 0; b < int'(r); b++) exp_keep[b] = 1'b1;
    end
  endfunction

  // Ready driver, changing just after each rising edge.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: sample at the falling edge, compare handshakes against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!m_tvalid || m_tdata !== prev_data || m_tkeep !== prev_keep ||
            m_tlast !== prev_last) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b d=%0h k=%0h l=%0b, expected d=%0h k=%0h l=%0b",
                   m_tvalid, m_tdata, m_tkeep, m_tlast, prev_data, prev_keep, prev_last);
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got d=%0h, expected no beat", m_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", m_tdata, mon_e.data);
          check("beat_tag", {m_tlast, m_tkeep}, {mon_e.last, mon_e.keep});
        end
        beats++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (m_tlast) last_keep_seen = m_tkeep;
      end
      stall_prev = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_keep  = m_tkeep;
      prev_last  = m_tlast;
      if (err_zero_len) err_pulses++;
      if (dat_rden) dat_rd_cnt++;
      if (cnt_rden && cnt_rden_cyc < 0) cnt_rden_cyc = cyc;
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (int'(dut.u_skid.occ_o) > max_occ) max_occ = int'(dut.u_skid.occ_o);
    end
  end

  task automatic clear_stats();
    beats = 0; first_hs = -1; last_hs = -1; cnt_rden_cyc = -1; first_valid_cyc = -1;
    err_pulses = 0; dat_rd_cnt = 0; max_occ = 0; last_keep_seen = 8'h00;
  endtask

  task automatic push_count(input int unsigned bytes);
    cnt_mem[cnt_wr[5:0]] = {32'($urandom), 16'($urandom), 16'(bytes)};
    cnt_wr++;
  endtask

  task automatic push_words(input int unsigned bytes, input int first, input int n);
    int total;
    beat_t b;
    total = int'((bytes + 7) / 8);
    for (int k = first; k < first + n; k++) begin
      b.data = {32'($urandom), 32'($urandom)};
      b.last = (k == total - 1);
      b.keep = exp_keep(bytes, b.last);
      dat_mem[dat_wr[9:0]] = b.data;
      dat_wr++;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_pkt(input logic [15:0] target, input string name);
    int n;
    n = 0;
    while (pkt_cnt !== target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({"pkt_done_", name}, pkt_cnt, target);
    @(negedge clk);
  endtask

  logic [15:0] pkts_exp;

  initial begin
    vecs[0] = '{bytes: 64, ready_mode: 0, exp_beats: 8, exp_last_keep: 8'hFF};
    vecs[1] = '{bytes: 13, ready_mode: 0, exp_beats: 2, exp_last_keep: 8'h1F};
    vecs[2] = '{bytes: 8,  ready_mode: 0, exp_beats: 1, exp_last_keep: 8'hFF};
    vecs[3] = '{bytes: 40, ready_mode: 1, exp_beats: 5, exp_last_keep: 8'hFF};
    vecs[4] = '{bytes: 1,  ready_mode: 0, exp_beats: 1, exp_last_keep: 8'h01};
    vecs[5] = '{bytes: 23, ready_mode: 2, exp_beats: 3, exp_last_keep: 8'h7F};
    pkts_exp = 16'd0;
    clear_stats();

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tkeep", m_tkeep, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_cnt_rden", cnt_rden, 0);
    check("rst_dat_rden", dat_rden, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_zero_len, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      rdy_mode = int'(v.ready_mode);
      clear_stats();
      push_words(v.bytes, 0, int'(v.exp_beats));
      push_count(v.bytes);
      pkts_exp++;
      wait_pkt(pkts_exp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_beats", i), beats, v.exp_beats);
      check($sformatf("vec%0d_last_keep", i), last_keep_seen, v.exp_last_keep);
      check($sformatf("vec%0d_sb_empty", i), exp_q.size(), 0);
      check($sformatf("vec%0d_idle", i), busy, 0);
      check($sformatf("vec%0d_occ_max", i), max_occ <= 2, 1);
      if (v.ready_mode == 0) begin
        check($sformatf("vec%0d_throughput", i), last_hs - first_hs, v.exp_beats - 1);
        // tvalid rises on the third edge after the edge that pops the count.
        check($sformatf("vec%0d_latency", i), first_valid_cyc - cnt_rden_cyc, 4);
      end
    end

    // Zero-length entry followed by a normal one.
    rdy_mode = 0;
    clear_stats();
    push_words(8, 0, 1);
    push_count(0);
    push_count(8);
    pkts_exp++;
    wait_pkt(pkts_exp, "after_zero");
    check("zero_err_pulses", err_pulses, 1);
    check("zero_dat_reads", dat_rd_cnt, 1);
    check("zero_next_beats", beats, 1);
    check("zero_sb_empty", exp_q.size(), 0);

    // Data FIFO runs dry after 2 of 4 words.
    clear_stats();
    push_words(32, 0, 2);
    push_count(32);
    repeat (20) @(negedge clk);
    check("stall_beats", beats, 2);
    check("stall_busy", busy, 1);
    check("stall_tvalid", m_tvalid, 0);
    check("stall_pkt_cnt", pkt_cnt, pkts_exp);
    push_words(32, 2, 2);
    pkts_exp++;
    wait_pkt(pkts_exp, "stall");
    check("stall_total_beats", beats, 4);
    check("stall_last_keep", last_keep_seen, 8'hFF);
    check("stall_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a transfer.
    clear_stats();
    push_words(64, 0, 8);
    push_count(64);
    begin
      int n;
      n = 0;
      while (beats < 3 && n < 200) begin
        @(posedge clk);
        n++;
      end
    end
    check("mid_reached", beats >= 3, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_tkeep", m_tkeep, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_dat_rden", dat_rden, 0);
    check("mid_rst_cnt_rden", cnt_rden, 0);
    exp_q.delete();
    dat_flush = 1'b1;
    @(posedge clk);
    #1 dat_flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pkts_exp = 16'd0;
    @(negedge clk);
    clear_stats();
    push_words(13, 0, 2);
    push_count(13);
    pkts_exp++;
    wait_pkt(pkts_exp, "post_reset");
    check("post_rst_beats", beats, 2);
    check("post_rst_last_keep", last_keep_seen, 8'h1F);
    check("post_rst_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
